cnn_frame_ctrl: RTL and testbench

CNN_FRAME_CTRL -- requirements
Module: cnn_frame_ctrl

---
 rtl/cnn_ctrl_pkg.sv | 19 +
 rtl/cnn_frame_ctrl_if.sv | 55 +++++
 rtl/cnn_sync_cnt.sv | 48 ++++
 rtl/cnn_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cnn_frame_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN frame controller.
// Holds the controller state encoding and the compile-time check for the
// number of pixels carried per beat.
package cnn_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StVsync = 3'd1,
      StHsync = 3'd2,
      StData  = 3'd3,
      StDone  = 3'd4
   } ctrl_state_e;

   // Only power-of-two lane counts up to 4 are supported by the column stepping.
   function automatic bit ppc_legal(input int unsigned ppc);
      return (ppc == 1) || (ppc == 2) || (ppc == 4);
   endfunction

endpackage

// File: rtl/cnn_frame_ctrl_if.sv
// Configuration, handshake and status bundle for cnn_frame_ctrl.
//   q_*      : run configuration and start request (sampled only when idle)
//   i_abort  : synchronous cancel
//   i_ready  : downstream accepts the current beat
//   o_*      : state flags, position counters and position flags
// Modports: master drives configuration/handshake, slave is the controller.
interface cnn_frame_ctrl_if #(
   parameter int unsigned W_SIZE  = 12,
   parameter int unsigned W_DELAY = 12,
   parameter int unsigned W_CH    = 8
);

   logic [W_SIZE-1:0]   q_width;
   logic [W_SIZE-1:0]   q_height;
   logic [W_DELAY-1:0]  q_vsync_delay;
   logic [W_DELAY-1:0]  q_hsync_delay;
   logic [W_CH-1:0]     q_num_ch;
   logic                q_start;
   logic                i_abort;
   logic                i_ready;

   logic                o_ctrl_vsync_run;
   logic                o_ctrl_hsync_run;
   logic                o_ctrl_data_run;
   logic [W_SIZE-1:0]   o_row;
   logic [W_SIZE-1:0]   o_col;
   logic [W_CH-1:0]     o_ch;
   logic [2*W_SIZE-1:0] o_data_count;
   logic                o_first_row;
   logic                o_last_row;
   logic                o_end_line;
   logic                o_end_frame;
   logic                o_half_frame;
   logic                o_busy;
   logic                o_done;

   modport master (
      output q_width, q_height, q_vsync_delay, q_hsync_delay, q_num_ch, q_start,
      output i_abort, i_ready,
      input  o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run,
      input  o_row, o_col, o_ch, o_data_count,
      input  o_first_row, o_last_row, o_end_line, o_end_frame, o_half_frame,
      input  o_busy, o_done
   );

   modport slave (
      input  q_width, q_height, q_vsync_delay, q_hsync_delay, q_num_ch, q_start,
      input  i_abort, i_ready,
      output o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run,
      output o_row, o_col, o_ch, o_data_count,
      output o_first_row, o_last_row, o_end_line, o_end_frame, o_half_frame,
      output o_busy, o_done
   );

endinterface

// File: rtl/cnn_sync_cnt.sv
// Blanking-interval counter.
//   clk, rstn     : clock, asynchronous active-low reset
//   load_i        : capture load_val_i as terminal value and restart from 0
//   load_val_i    : terminal value (blanking length minus 1)
//   clr_i         : restart count from 0, terminal value kept
//   en_i          : advance count by one
//   match_o       : count equals terminal value
module cnn_sync_cnt #(
   parameter int unsigned W = 12
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         clr_i,
   input  logic         en_i,
   output logic         match_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] term_q, term_d;

   always_comb begin
      cnt_d  = cnt_q;
      term_d = term_q;
      if (load_i) begin
         term_d = load_val_i;
         cnt_d  = '0;
      end else if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q  <= '0;
         term_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         term_q <= term_d;
      end
   end

   assign match_o = (cnt_q == term_q);

endmodule

// File: rtl/cnn_frame_ctrl.sv
// Frame/line/beat sequencer for a CNN feature-map streamer.
// Walks num_ch frames of height lines of width pixels, PPC pixels per beat,
// inserting a vertical blanking interval before each frame and a horizontal
// one before each line. Data beats advance only when i_ready is high.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : configuration, abort/ready handshake and status outputs
module cnn_frame_ctrl
   import cnn_ctrl_pkg::*;
#(
   parameter int unsigned W_SIZE  = 12,
   parameter int unsigned W_DELAY = 12,
   parameter int unsigned W_CH    = 8,
   parameter int unsigned PPC     = 1
) (
   input logic              clk,
   input logic              rstn,
   cnn_frame_ctrl_if.slave  bus
);

   if (!ppc_legal(PPC)) begin : g_ppc_check
      $error("cnn_frame_ctrl: PPC must be 1, 2 or 4");
   end

   localparam int unsigned    WCnt = 2 * W_SIZE;
   localparam logic [W_SIZE-1:0] PpcW = W_SIZE'(PPC);

   ctrl_state_e       state_q, state_d;
   logic [W_SIZE-1:0] width_q, width_d;
   logic [W_SIZE-1:0] height_q, height_d;
   logic [W_CH-1:0]   nch_q, nch_d;
   logic [W_SIZE-1:0] row_q, row_d;
   logic [W_SIZE-1:0] col_q, col_d;
   logic [W_CH-1:0]   ch_q, ch_d;
   logic [WCnt-1:0]   cnt_q, cnt_d;

   logic              start_ok;
   logic              degenerate;
   logic              v_match, h_match;
   logic              in_data;
   logic              end_line, end_frame;
   logic [WCnt-1:0]   frame_beats, half_idx;

   assign start_ok   = (state_q == StIdle) & bus.q_start & ~bus.i_abort;
   assign degenerate = (bus.q_width < PpcW) | (bus.q_height == '0) | (bus.q_num_ch == '0);
   assign in_data    = (state_q == StData);

   // Blanking counters are cleared on the cycle they match so they re-enter at 0.
   cnn_sync_cnt #(.W(W_DELAY)) u_vsync_cnt (
      .clk        (clk),
      .rstn       (rstn),
      .load_i     (start_ok),
      .load_val_i (bus.q_vsync_delay),
      .clr_i      (bus.i_abort | ((state_q == StVsync) & v_match)),
      .en_i       (state_q == StVsync),
      .match_o    (v_match)
   );

   cnn_sync_cnt #(.W(W_DELAY)) u_hsync_cnt (
      .clk        (clk),
      .rstn       (rstn),
      .load_i     (start_ok),
      .load_val_i (bus.q_hsync_delay),
      .clr_i      (bus.i_abort | ((state_q == StHsync) & h_match)),
      .en_i       (state_q == StHsync),
      .match_o    (h_match)
   );

   // Full-width product so large frames do not wrap the half-frame index.
   assign frame_beats = {{W_SIZE{1'b0}}, width_q / PpcW} * {{W_SIZE{1'b0}}, height_q};
   assign half_idx    = (frame_beats >> 1) - WCnt'(1);

   assign end_line  = in_data & (col_q == width_q - PpcW);
   assign end_frame = end_line & (row_q == height_q - W_SIZE'(1));

   always_comb begin
      state_d  = state_q;
      width_d  = width_q;
      height_d = height_q;
      nch_d    = nch_q;
      row_d    = row_q;
      col_d    = col_q;
      ch_d     = ch_q;
      cnt_d    = cnt_q;

      if (bus.i_abort) begin
         state_d = StIdle;
         row_d   = '0;
         col_d   = '0;
         ch_d    = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.q_start) begin
                  width_d  = bus.q_width;
                  height_d = bus.q_height;
                  nch_d    = bus.q_num_ch;
                  state_d  = degenerate ? StDone : StVsync;
               end
            end
            StVsync: if (v_match) state_d = StHsync;
            StHsync: if (h_match) state_d = StData;
            StData: begin
               if (bus.i_ready) begin
                  cnt_d = cnt_q + WCnt'(1);
                  col_d = col_q + PpcW;
                  if (end_frame) begin
                     row_d = '0;
                     col_d = '0;
                     cnt_d = '0;
                     if (ch_q == nch_q - W_CH'(1)) begin
                        state_d = StDone;
                     end else begin
                        ch_d    = ch_q + W_CH'(1);
                        state_d = StVsync;
                     end
                  end else if (end_line) begin
                     col_d   = '0;
                     row_d   = row_q + W_SIZE'(1);
                     state_d = StHsync;
                  end
               end
            end
            StDone: begin
               ch_d    = '0;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= StIdle;
         width_q  <= '0;
         height_q <= '0;
         nch_q    <= '0;
         row_q    <= '0;
         col_q    <= '0;
         ch_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         width_q  <= width_d;
         height_q <= height_d;
         nch_q    <= nch_d;
         row_q    <= row_d;
         col_q    <= col_d;
         ch_q     <= ch_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.o_ctrl_vsync_run = (state_q == StVsync);
   assign bus.o_ctrl_hsync_run = (state_q == StHsync);
   assign bus.o_ctrl_data_run  = in_data;
   assign bus.o_row            = row_q;
   assign bus.o_col            = col_q;
   assign bus.o_ch             = ch_q;
   assign bus.o_data_count     = cnt_q;
   assign bus.o_first_row      = in_data & (row_q == '0);
   assign bus.o_last_row       = in_data & (row_q == height_q - W_SIZE'(1));
   assign bus.o_end_line       = end_line;
   assign bus.o_end_frame      = end_frame;
   assign bus.o_half_frame     = in_data & (cnt_q == half_idx);
   assign bus.o_busy           = (state_q != StIdle);
   // An abort arriving in the DONE cycle cancels the completion pulse.
   assign bus.o_done           = (state_q == StDone) & ~bus.i_abort;

endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Self-checking bench for cnn_frame_ctrl: one PPC=1 and one PPC=4 instance.
// Expected per-cycle outputs come from a trace of the run built from the frame
// geometry (blanking slots, beats per line), consumed one entry per cycle and
// held while a data beat is stalled.
module tb_cnn_frame_ctrl;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   cnn_frame_ctrl_if #(.W_SIZE(12), .W_DELAY(12), .W_CH(8)) bus1 ();
   cnn_frame_ctrl_if #(.W_SIZE(12), .W_DELAY(12), .W_CH(8)) bus4 ();

   cnn_frame_ctrl #(.W_SIZE(12), .W_DELAY(12), .W_CH(8), .PPC(1)) dut1 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus1)
   );

   cnn_frame_ctrl #(.W_SIZE(12), .W_DELAY(12), .W_CH(8), .PPC(4)) dut4 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus4)
   );

   logic [11:0] t_width [2];
   logic [11:0] t_height [2];
   logic [11:0] t_vd [2];
   logic [11:0] t_hd [2];
   logic [7:0]  t_nch [2];
   logic        t_start [2];
   logic        t_abort [2];
   logic        t_ready [2];
   logic [65:0] obs [2];

   assign bus1.q_width = t_width[0];        assign bus4.q_width = t_width[1];
   assign bus1.q_height = t_height[0];      assign bus4.q_height = t_height[1];
   assign bus1.q_vsync_delay = t_vd[0];     assign bus4.q_vsync_delay = t_vd[1];
   assign bus1.q_hsync_delay = t_hd[0];     assign bus4.q_hsync_delay = t_hd[1];
   assign bus1.q_num_ch = t_nch[0];         assign bus4.q_num_ch = t_nch[1];
   assign bus1.q_start = t_start[0];        assign bus4.q_start = t_start[1];
   assign bus1.i_abort = t_abort[0];        assign bus4.i_abort = t_abort[1];
   assign bus1.i_ready = t_ready[0];        assign bus4.i_ready = t_ready[1];

   // [65]vsync [64]hsync [63]data [62]busy [61]done [60]first [59]last [58]eol
   // [57]eof [56]half [55:44]row [43:32]col [31:24]ch [23:0]count
   assign obs[0] = {bus1.o_ctrl_vsync_run, bus1.o_ctrl_hsync_run, bus1.o_ctrl_data_run,
                    bus1.o_busy, bus1.o_done, bus1.o_first_row, bus1.o_last_row,
                    bus1.o_end_line, bus1.o_end_frame, bus1.o_half_frame,
                    bus1.o_row, bus1.o_col, bus1.o_ch, bus1.o_data_count};
   assign obs[1] = {bus4.o_ctrl_vsync_run, bus4.o_ctrl_hsync_run, bus4.o_ctrl_data_run,
                    bus4.o_busy, bus4.o_done, bus4.o_first_row, bus4.o_last_row,
                    bus4.o_end_line, bus4.o_end_frame, bus4.o_half_frame,
                    bus4.o_row, bus4.o_col, bus4.o_ch, bus4.o_data_count};

   // Phase codes: 1 vsync, 2 hsync, 3 data, 4 done.
   typedef struct {
      int st;
      int row;
      int col;
      int ch;
      int cnt;
      bit first;
      bit last;
      bit eol;
      bit eof;
      bit half;
   } rec_t;

   rec_t trace[$];
   int   n_chk;
   int   n_pass;

   task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic logic [65:0] exp_vec(input rec_t r);
      return {r.st == 1, r.st == 2, r.st == 3, 1'b1, r.st == 4,
              r.first, r.last, r.eol, r.eof, r.half,
              12'(r.row), 12'(r.col), 8'(r.ch), 24'(r.cnt)};
   endfunction

   function automatic rec_t mk(input int st, row, col, ch, cnt);
      rec_t r;
      r.st = st; r.row = row; r.col = col; r.ch = ch; r.cnt = cnt;
      r.first = 0; r.last = 0; r.eol = 0; r.eof = 0; r.half = 0;
      return r;
   endfunction

   task automatic build(input int ppc, w, h, vd, hd, nch);
      int   bpr;
      int   total;
      rec_t r;
      trace.delete();
      if (w < ppc || h == 0 || nch == 0) begin
         trace.push_back(mk(4, 0, 0, 0, 0));
         return;
      end
      bpr   = w / ppc;
      total = bpr * h;
      for (int c = 0; c < nch; c++) begin
         for (int i = 0; i <= vd; i++) trace.push_back(mk(1, 0, 0, c, 0));
         for (int rw = 0; rw < h; rw++) begin
            for (int i = 0; i <= hd; i++) trace.push_back(mk(2, rw, 0, c, rw * bpr));
            for (int b = 0; b < bpr; b++) begin
               r       = mk(3, rw, b * ppc, c, rw * bpr + b);
               r.first = (rw == 0);
               r.last  = (rw == h - 1);
               r.eol   = (b == bpr - 1);
               r.eof   = r.eol && r.last;
               r.half  = (rw * bpr + b) == (total / 2 - 1);
               trace.push_back(r);
            end
         end
      end
      trace.push_back(mk(4, 0, 0, nch - 1, 0));
   endtask

   task automatic scramble(input int d);
      t_width[d]  = 12'($urandom);
      t_height[d] = 12'($urandom);
      t_vd[d]     = 12'($urandom);
      t_hd[d]     = 12'($urandom);
      t_nch[d]    = 8'($urandom);
   endtask

   // Called at posedge+1. mode: 0 always ready, 1 random ready, 2 five-cycle
   // stall when beat 2 is presented. ab_ch/ab_row < 0 disables the abort.
   task automatic run_trace(input int d, w, h, vd, hd, nch, mode, ab_ch, ab_row);
      int   ppc;
      int   budget;
      int   beats;
      int   stall;
      bit   stalled;
      bit   ready;
      bit   aborted;
      rec_t head;
      ppc = (d == 0) ? 1 : 4;
      build(ppc, w, h, vd, hd, nch);
      t_width[d] = 12'(w); t_height[d] = 12'(h); t_vd[d] = 12'(vd); t_hd[d] = 12'(hd);
      t_nch[d] = 8'(nch); t_start[d] = 1'b1;
      @(posedge clk); #1;
      t_start[d] = 1'b0;
      budget = 4000; beats = 0; stall = 0; stalled = 0; aborted = 0;
      while (trace.size() > 0 && budget > 0) begin
         head = trace[0];
         case (mode)
            0: ready = 1'b1;
            1: ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (head.st == 3 && head.cnt == 2 && !stalled) begin
                  stall   = 5;
                  stalled = 1;
               end
               ready = (stall == 0);
               if (stall > 0) stall--;
            end
         endcase
         t_ready[d] = ready;
         scramble(d);
         if (head.st == 3 && head.ch == ab_ch && head.row == ab_row) t_abort[d] = 1'b1;
         #1;
         check("trace", obs[d], exp_vec(head));
         if (obs[d][63] && ready) beats++;
         if (t_abort[d]) begin
            @(posedge clk); #1;
            t_abort[d] = 1'b0;
            for (int i = 0; i < 4; i++) begin
               check("abort_idle", obs[d], 66'd0);
               @(posedge clk); #1;
            end
            trace.delete();
            aborted = 1;
         end else begin
            if (!(head.st == 3 && !ready)) void'(trace.pop_front());
            @(posedge clk); #1;
            budget--;
         end
      end
      check("timeout", 66'(trace.size()), 66'd0);
      if (!aborted) begin
         t_ready[d] = 1'b1;
         #1;
         check("idle_after", obs[d], 66'd0);
         check("beat_count", 66'(beats), (w < ppc) ? 66'd0 : 66'((w / ppc) * h * nch));
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bit found;
      n_chk = 0;
      n_pass = 0;
      for (int d = 0; d < 2; d++) begin
         t_width[d] = '0; t_height[d] = '0; t_vd[d] = '0; t_hd[d] = '0; t_nch[d] = '0;
         t_start[d] = 1'b0; t_abort[d] = 1'b0; t_ready[d] = 1'b0;
      end
      rstn = 1'b0;
      #3;
      check("reset_p1", obs[0], 66'd0);
      check("reset_p4", obs[1], 66'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      check("idle_p1", obs[0], 66'd0);

      // Basic frame, lane/channel sweep, backpressure.
      run_trace(0, 4, 2, 1, 1, 1, 0, -1, -1);
      run_trace(1, 8, 2, $urandom_range(0, 2), $urandom_range(0, 2), 3, 0, -1, -1);
      run_trace(0, 4, 2, 1, 1, 1, 2, -1, -1);

      // Randomised geometry with random ready.
      for (int i = 0; i < 6; i++)
         run_trace(0, $urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), $urandom_range(1, 2), 1, -1, -1);
      for (int i = 0; i < 3; i++)
         run_trace(1, 4 * $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom_range(1, 3), 1, -1, -1);

      // Abort in row 1 of channel 1, then a clean run.
      run_trace(0, 4, 2, 1, 0, 2, 0, 1, 1);
      run_trace(0, 4, 2, 1, 1, 1, 0, -1, -1);

      // Degenerate configurations.
      run_trace(0, 4, 0, 1, 1, 1, 0, -1, -1);
      run_trace(0, 4, 2, 1, 1, 0, 0, -1, -1);
      run_trace(1, 2, 2, 1, 1, 1, 0, -1, -1);

      // Asynchronous reset in the middle of a data phase.
      t_width[0] = 12'd4; t_height[0] = 12'd2; t_vd[0] = 12'd1; t_hd[0] = 12'd1;
      t_nch[0] = 8'd1; t_start[0] = 1'b1; t_ready[0] = 1'b1;
      @(posedge clk); #1;
      t_start[0] = 1'b0;
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (obs[0][63]) found = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      check("wait_data", 66'(found), 66'd1);
      @(posedge clk); #2;
      rstn = 1'b0;
      #1;
      check("async_rst", obs[0], 66'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("post_rst_idle", obs[0], 66'd0);
         @(posedge clk); #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
